// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file peripheral.
//   spi_state_e     : frame-level FSM states
//   SPI_RW_WRITE/READ: encoding of the first frame bit
//   sample_on_rise  : selects the SCLK edge that captures MOSI for a given mode
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        DATA    = 3'd3,
        COMMIT  = 3'd4,
        WAIT_CS = 3'd5
    } spi_state_e;

    localparam logic SPI_RW_WRITE = 1'b1;
    localparam logic SPI_RW_READ  = 1'b0;

    // Modes 0 and 3 capture on the rising SCLK edge, modes 1 and 2 on the falling one.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with an extra history
// flop that turns level changes into single-cycle rise/fall pulses.
// Ports:
//   i_clk, i_rst_n : system clock, synchronous active-low reset
//   i_async        : asynchronous pin input
//   o_level        : synchronised level
//   o_rise/o_fall  : one-cycle pulses on synchronised transitions
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_async};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q[STAGES-1];
    assign o_rise  = sync_q[STAGES-1] & ~prev_q;
    assign o_fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI slave register file, oversampled on i_clk. Frame (MSB first):
// R/W bit (1 = write), ADDR_W address bits, DATA_W data bits.
// Reads return the addressed register on MISO during the data phase.
// Optional feature macro: SPI_BURST_EN (address auto-increment across words).
// Ports:
//   i_clk, i_rst_n       : system clock, synchronous active-low reset
//   i_sclk, i_cs_n, i_mosi : asynchronous SPI pins
//   o_miso, o_miso_oe    : slave data out and its enable (enable = CS low)
//   o_regs               : flattened register file, reg k at [k*DATA_W +: DATA_W]
//   o_wr_strobe          : one-cycle pulse per register, aligned with its update
//   o_frame_err          : one-cycle pulse when a frame is cut short by CS
//
// state   | meaning
// IDLE    | waiting for a CS falling edge
// CMD     | capturing the R/W bit
// ADDR    | shifting in the address; read data preloaded on the last bit
// DATA    | shifting data in on sample edges, read data out on shift edges
// COMMIT  | single cycle applying a write
// WAIT_CS | frame done, ignoring SCLK until CS rises
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_sclk,
    input  logic                       i_cs_n,
    input  logic                       i_mosi,
    output logic                       o_miso,
    output logic                       o_miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] o_regs,
    output logic [NUM_REGS-1:0]        o_wr_strobe,
    output logic                       o_frame_err
);

    localparam int   MAX_W       = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int   CNT_W       = $clog2(MAX_W + 1);
    localparam int   FL_W        = $clog2(SYNC_STAGES + 1);
    localparam logic SAMPLE_RISE = sample_on_rise(1'(CPOL), 1'(CPHA));

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_sclk),
        .o_level (sclk_level),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_cs_n),
        .o_level (cs_level),
        .o_rise  (cs_rise),
        .o_fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_mosi),
        .o_level (mosi_level),
        .o_rise  (mosi_rise),
        .o_fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_level, cs_rise, mosi_rise, mosi_fall};

    logic sample_edge, shift_edge;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

    spi_state_e           state_q, state_d;
    logic                 rw_q, rw_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [DATA_W-1:0]    tx_q, tx_d;
    logic                 miso_q, miso_d;
    logic                 in_burst_q, in_burst_d;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [DATA_W-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  wr_strobe_q, wr_strobe_d;
    logic                 frame_err_q, frame_err_d;
    logic [FL_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                 armed_q, armed_d;

    // Reset preloads the CS chain high, so if CS is physically low when reset
    // releases, the chain draining produces a false falling edge. Frames are
    // only accepted once CS has been seen high after the chain has flushed.
    always_comb begin
        flush_cnt_d = (flush_cnt_q != '0) ? flush_cnt_q - FL_W'(1) : flush_cnt_q;
        armed_d     = armed_q | ((flush_cnt_q == '0) & cs_level);
    end

    logic [ADDR_W-1:0] addr_shift, addr_inc, rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign addr_shift = {addr_q[ADDR_W-2:0], mosi_level};
    assign addr_inc   = addr_q + ADDR_W'(1);

    // Read preload address: the address being completed, or the next burst word.
    always_comb begin
        rd_addr = (state_q == ADDR) ? addr_shift : addr_inc;
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) rd_data = regs_q[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        in_burst_d  = in_burst_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d       = '0;
                miso_d     = 1'b0;
                bit_cnt_d  = '0;
                in_burst_d = 1'b0;
                if (cs_fall && armed_q) state_d = CMD;
            end

            CMD: begin
                if (cs_level) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sample_edge) begin
                    rw_d      = mosi_level;
                    bit_cnt_d = CNT_W'(ADDR_W - 1);
                    state_d   = ADDR;
                end
            end

            ADDR: begin
                if (cs_level) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sample_edge) begin
                    addr_d = addr_shift;
                    if (bit_cnt_q == '0) begin
                        state_d   = DATA;
                        bit_cnt_d = CNT_W'(DATA_W - 1);
                        if (rw_q == SPI_RW_READ) tx_d = rd_data;
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end

            DATA: begin
                if (cs_level) begin
                    state_d = IDLE;
                    // CS rising before any bit of a follow-on burst word is a clean end.
                    frame_err_d = ~(in_burst_q && (bit_cnt_q == CNT_W'(DATA_W - 1)));
                end else begin
                    if (shift_edge) begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = tx_q << 1;
                    end
                    if (sample_edge) begin
                        data_d = {data_q[DATA_W-2:0], mosi_level};
                        if (bit_cnt_q == '0) state_d = COMMIT;
                        else                 bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end

            COMMIT: begin
                if (rw_q == SPI_RW_WRITE) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (addr_q == ADDR_W'(k)) begin
                            regs_d[k]      = data_q;
                            wr_strobe_d[k] = 1'b1;
                        end
                    end
                end
`ifdef SPI_BURST_EN
                if (!cs_level) begin
                    addr_d     = addr_inc;
                    bit_cnt_d  = CNT_W'(DATA_W - 1);
                    in_burst_d = 1'b1;
                    state_d    = DATA;
                    if (rw_q == SPI_RW_READ) tx_d = rd_data;
                end else begin
                    state_d = WAIT_CS;
                end
`else
                state_d = WAIT_CS;
`endif
            end

            WAIT_CS: begin
                if (cs_level) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            in_burst_q  <= 1'b0;
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
            flush_cnt_q <= FL_W'(SYNC_STAGES);
            armed_q     <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            in_burst_q  <= in_burst_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            flush_cnt_q <= flush_cnt_d;
            armed_q     <= armed_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign o_regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign o_miso_oe   = ~cs_level;
    assign o_miso      = ~cs_level & miso_q;
    assign o_wr_strobe = wr_strobe_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
module tb_spi_regfile_peripheral;

    localparam int HALF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   sel;
    logic m_sclk, m_cs, m_mosi;

    logic sclk0, cs0, sclk3, cs3;
    assign sclk0 = (sel == 0) ? m_sclk : 1'b0;
    assign cs0   = (sel == 0) ? m_cs   : 1'b1;
    assign sclk3 = (sel == 1) ? m_sclk : 1'b1;
    assign cs3   = (sel == 1) ? m_cs   : 1'b1;

    logic        miso0, oe0, err0, miso3, oe3, err3;
    logic [63:0] regs0, regs3;
    logic [7:0]  strobe0, strobe3;

    spi_regfile_peripheral #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(7), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_m0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk0), .i_cs_n(cs0), .i_mosi(m_mosi),
        .o_miso(miso0), .o_miso_oe(oe0), .o_regs(regs0), .o_wr_strobe(strobe0), .o_frame_err(err0)
    );

    spi_regfile_peripheral #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(7), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_m3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk3), .i_cs_n(cs3), .i_mosi(m_mosi),
        .o_miso(miso3), .o_miso_oe(oe3), .o_regs(regs3), .o_wr_strobe(strobe3), .o_frame_err(err3)
    );

    typedef struct {
        int         sel;
        int         idx;
        logic [7:0] val;
    } wr_ev_t;

    wr_ev_t     exp_wr_q[$];
    wr_ev_t     obs_wr_q[$];
    logic       exp_bit_q[$];
    logic [7:0] mdl [2][8];
    int         err_cnt0 = 0;
    int         err_cnt3 = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (strobe0[k] === 1'b1) obs_wr_q.push_back('{sel: 0, idx: k, val: regs0[k*8 +: 8]});
            if (strobe3[k] === 1'b1) obs_wr_q.push_back('{sel: 1, idx: k, val: regs3[k*8 +: 8]});
        end
        if (err0 === 1'b1) err_cnt0++;
        if (err3 === 1'b1) err_cnt3++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int s);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = mdl[s][k];
        return r;
    endfunction

    task automatic half_wait();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_start(input int s);
        sel    = s;
        m_sclk = (s == 1);
        m_cs   = 1'b1;
        m_mosi = 1'b0;
        half_wait();
        m_cs = 1'b0;
        half_wait();
    endtask

    task automatic spi_end();
        half_wait();
        m_cs = 1'b1;
        repeat (4*HALF) @(negedge clk);
    endtask

    task automatic sample_miso();
        logic m, oe, e;
        m  = (sel == 1) ? miso3 : miso0;
        oe = (sel == 1) ? oe3 : oe0;
        e  = (exp_bit_q.size() > 0) ? exp_bit_q.pop_front() : 1'bx;
        chk("miso_bit", 64'(m), 64'(e));
        chk("miso_oe_low_cs", 64'(oe), 64'd1);
    endtask

    task automatic spi_bits(input logic [31:0] frame, input int from, input int to, input bit chk_rd);
        logic cp;
        cp = (sel == 1);
        for (int i = from; i < to; i++) begin
            if (!cp) begin
                m_mosi = frame[31-i];
                half_wait();
                m_sclk = 1'b1;
                if (chk_rd && i >= 8) sample_miso();
                half_wait();
                m_sclk = 1'b0;
            end else begin
                m_sclk = 1'b0;
                m_mosi = frame[31-i];
                half_wait();
                m_sclk = 1'b1;
                if (chk_rd && i >= 8) sample_miso();
                half_wait();
            end
        end
    endtask

    task automatic write_frame(input int s, input logic [6:0] addr, input logic [7:0] data);
        if (addr < 7'd8) begin
            mdl[s][addr[2:0]] = data;
            exp_wr_q.push_back('{sel: s, idx: int'(addr), val: data});
        end
        spi_start(s);
        spi_bits({1'b1, addr, data, 16'h0000}, 0, 16, 1'b0);
        spi_end();
    endtask

    task automatic read_frame(input int s, input logic [6:0] addr);
        logic [7:0] e;
        e = (addr < 7'd8) ? mdl[s][addr[2:0]] : 8'h00;
        for (int b = 7; b >= 0; b--) exp_bit_q.push_back(e[b]);
        spi_start(s);
        spi_bits({1'b0, addr, 8'h00, 16'h0000}, 0, 16, 1'b1);
        spi_end();
        chk("rd_bits_drained", 64'(exp_bit_q.size()), 64'd0);
        chk("miso_oe_after_cs", 64'((s == 1) ? oe3 : oe0), 64'd0);
        exp_bit_q.delete();
    endtask

    task automatic check_wr(input string tag);
        wr_ev_t o, e;
        chk({tag, "_nwr"}, 64'(obs_wr_q.size()), 64'(exp_wr_q.size()));
        while (obs_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
            o = obs_wr_q.pop_front();
            e = exp_wr_q.pop_front();
            chk({tag, "_wr_ev"}, 64'(o.sel*4096 + o.idx*256 + int'(o.val)),
                                 64'(e.sel*4096 + e.idx*256 + int'(e.val)));
        end
        obs_wr_q.delete();
        exp_wr_q.delete();
        chk({tag, "_regs_m0"}, regs0, pack(0));
        chk({tag, "_regs_m3"}, regs3, pack(1));
    endtask

    initial begin
        int err_before;
        rst_n  = 1'b0;
        sel    = 0;
        m_sclk = 1'b0;
        m_cs   = 1'b1;
        m_mosi = 1'b0;
        for (int s = 0; s < 2; s++) for (int k = 0; k < 8; k++) mdl[s][k] = 8'h00;

        repeat (4) @(negedge clk);
        chk("rst_regs_m0", regs0, 64'd0);
        chk("rst_regs_m3", regs3, 64'd0);
        chk("rst_strobe_m0", 64'(strobe0), 64'd0);
        chk("rst_err_m0", 64'(err0), 64'd0);
        chk("rst_miso_m0", 64'(miso0), 64'd0);
        chk("rst_oe_m0", 64'(oe0), 64'd0);
        chk("rst_oe_m3", 64'(oe3), 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        write_frame(0, 7'h03, 8'hA5);
        check_wr("m0_wr3");
        chk("m0_wr3_slice", 64'(regs0[31:24]), 64'hA5);

        write_frame(1, 7'h01, 8'h5C);
        check_wr("m3_wr1");
        read_frame(1, 7'h01);

        write_frame(0, 7'h7F, 8'hFF);
        check_wr("m0_wr_oob");
        read_frame(0, 7'h7F);
        read_frame(0, 7'h03);
        chk("no_err_so_far_m0", 64'(err_cnt0), 64'd0);

        err_before = err_cnt0;
        spi_start(0);
        spi_bits({1'b1, 7'h02, 8'hC3, 16'h0000}, 0, 12, 1'b0);
        spi_end();
        chk("abort_err_once", 64'(err_cnt0), 64'(err_before + 1));
        check_wr("abort_no_wr");
        write_frame(0, 7'h02, 8'h3C);
        check_wr("after_abort_wr2");
        chk("after_abort_no_err", 64'(err_cnt0), 64'(err_before + 1));

        err_before = err_cnt0;
        spi_start(0);
        spi_bits({1'b1, 7'h05, 8'hEE, 16'h0000}, 0, 4, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) for (int k = 0; k < 8; k++) mdl[s][k] = 8'h00;
        chk("midrst_regs_m0", regs0, 64'd0);
        chk("midrst_regs_m3", regs3, 64'd0);
        rst_n = 1'b1;
        spi_bits({1'b1, 7'h05, 8'hEE, 16'h0000}, 4, 16, 1'b0);
        spi_end();
        check_wr("midrst_stale_frame");
        write_frame(0, 7'h00, 8'h11);
        check_wr("midrst_wr0");
        chk("midrst_no_err", 64'(err_cnt0), 64'(err_before));

        err_before = err_cnt0;
`ifdef SPI_BURST_EN
        mdl[0][6] = 8'h01;
        mdl[0][7] = 8'h02;
        exp_wr_q.push_back('{sel: 0, idx: 6, val: 8'h01});
        exp_wr_q.push_back('{sel: 0, idx: 7, val: 8'h02});
`else
        mdl[0][6] = 8'h01;
        exp_wr_q.push_back('{sel: 0, idx: 6, val: 8'h01});
`endif
        spi_start(0);
        spi_bits({1'b1, 7'h06, 8'h01, 8'h02, 8'h03}, 0, 32, 1'b0);
        spi_end();
        check_wr("multiword");
        chk("multiword_no_err", 64'(err_cnt0), 64'(err_before));
        chk("m3_no_err", 64'(err_cnt3), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
